// File: rtl/mdio_arbitro.sv
// Round-robin arbiter sharing one generador_mdio between two requesters.
// Loads the winning frame, strobes the generator, counts MDC rises and captures read data.
module mdio_arbitro #(
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [31:0] trans0,
   input  logic [31:0] trans1,
   output logic [1:0]  grant,
   output logic [1:0]  done,
   output logic        err,
   output logic [15:0] rd_data,
   output logic        start_stb,
   output logic [31:0] transaccion,
   input  logic        mdc,
   input  logic        mdio_in
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_ONE = TW'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_d;
   logic          rr, owner, mdc_q;
   logic [5:0]    edge_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [15:0]   cap, cap_d;
   logic          rise, is_rd, win;
   logic [1:0]    grant_d, done_d;
   logic          start_d, err_d;

   assign rise  = mdc & ~mdc_q;
   assign is_rd = (transaccion[29:28] == 2'b10);
   // Round-robin only matters when both request; otherwise the lone requester wins.
   assign win   = (req == 2'b11) ? rr : req[1];
   // Rises 17..32 carry the read data, MSB first.
   assign cap_d = (is_rd && rise && edge_cnt[5:4] == 2'b01) ? {cap[14:0], mdio_in} : cap;

   always_comb begin
      state_d = state;
      grant_d = 2'b00;
      start_d = 1'b0;
      done_d  = 2'b00;
      err_d   = 1'b0;
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               state_d = RUN;
               grant_d = win ? 2'b10 : 2'b01;
               start_d = 1'b1;
            end
         end
         RUN: begin
            if (rise) begin
               if (edge_cnt == 6'd31) begin
                  state_d = DONE;
                  done_d  = owner ? 2'b10 : 2'b01;
               end
            end else if (tmo_cnt == TMO_MAX) begin
               state_d = DONE;
               done_d  = owner ? 2'b10 : 2'b01;
               err_d   = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         grant       <= 2'b00;
         start_stb   <= 1'b0;
         done        <= 2'b00;
         err         <= 1'b0;
         transaccion <= 32'h0;
         rd_data     <= 16'h0;
         rr          <= 1'b0;
         owner       <= 1'b0;
         mdc_q       <= 1'b0;
         edge_cnt    <= 6'd0;
         tmo_cnt     <= '0;
         cap         <= 16'h0;
      end else begin
         state     <= state_d;
         grant     <= grant_d;
         start_stb <= start_d;
         done      <= done_d;
         err       <= err_d;
         mdc_q     <= mdc;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  transaccion <= win ? trans1 : trans0;
                  owner       <= win;
                  edge_cnt    <= 6'd0;
                  tmo_cnt     <= '0;
               end
            end
            RUN: begin
               cap <= cap_d;
               if (rise) begin
                  edge_cnt <= edge_cnt + 6'd1;
                  tmo_cnt  <= '0;
               end else if (tmo_cnt != TMO_MAX) begin
                  tmo_cnt <= tmo_cnt + TMO_ONE;
               end
               // rd_data is updated together with done so it is valid during the pulse.
               if (state_d == DONE && is_rd)
                  rd_data <= err_d ? 16'hFFFF : cap_d;
            end
            DONE:    rr <= ~owner;
            default: ;
         endcase
      end
   end

endmodule
